// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Defines the FSM state type, the requester count and the rotating priority pick.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ = 4;

  // Search order is ptr+1, ptr+2, ptr+3, then ptr, so the last grantee has lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4x1.sv
// Plain N-bit 4:1 multiplexer, steered by the arbiter grant index.
module mux4x1 #(
  parameter int N = 8
) (
  input  logic [1:0]   i_sel,
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  input  logic [N-1:0] i_d2,
  input  logic [N-1:0] i_d3,
  output logic [N-1:0] o_q
);

  always_comb begin
    o_q = i_d0;
    case (i_sel)
      2'd0: o_q = i_d0;
      2'd1: o_q = i_d1;
      2'd2: o_q = i_d2;
      2'd3: o_q = i_d3;
      default: o_q = i_d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one N-bit stream among four valid/ready requesters.
// A grant lasts until a last beat or MAX_BURST accepted beats; one idle bubble separates bursts.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic [N-1:0]       in0,
  input  logic [N-1:0]       in1,
  input  logic [N-1:0]       in2,
  input  logic [N-1:0]       in3,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  output logic               out_last,
  output logic [1:0]         grant_sel,
  output logic               busy
);

  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [1:0] r_grant_sel;
  logic [1:0] w_grant_nxt;
  logic [7:0] r_beat_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_granted;
  logic       w_accept;
  logic       w_burst_end;

  assign w_granted   = (r_state == GRANT);
  assign out_valid   = w_granted && req_valid[r_grant_sel];
  assign req_ready   = w_granted ? (4'(out_ready) << r_grant_sel) : 4'b0000;
  assign out_last    = w_granted && (req_last[r_grant_sel] || (r_beat_cnt == LAST_CNT));
  assign w_accept    = out_valid && out_ready;
  // A last flag coinciding with the beat cap is one burst end, counted once.
  assign w_burst_end = w_accept && out_last;
  assign grant_sel   = r_grant_sel;
  assign busy        = w_granted;

  mux4x1 #(.N(N)) u_mux (
    .i_sel (r_grant_sel),
    .i_d0  (in0),
    .i_d1  (in1),
    .i_d2  (in2),
    .i_d3  (in3),
    .o_q   (out_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant_sel;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_grant_nxt = rr_pick(req_valid, r_ptr);
          w_cnt_nxt   = 8'd0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_burst_end) begin
          w_ptr_nxt   = r_grant_sel;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          w_cnt_nxt = r_beat_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pointer reset to 3 makes requester 0 the first choice after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd3;
      r_grant_sel <= 2'd0;
      r_beat_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant_sel <= w_grant_nxt;
      r_beat_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter with N=8, MAX_BURST=4.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] req_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] grant_sel;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  mux4_rr_arbiter #(.N(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .grant_sel (grant_sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rr_data [4];
    rr_data[0] = 8'h10; rr_data[1] = 8'h21; rr_data[2] = 8'h32; rr_data[3] = 8'h43;

    rst = 1'b1; req_valid = 4'b0000; req_last = 4'b0000; out_ready = 1'b1;
    in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
    #3;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_ready", req_ready, 4'b0000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_gsel", grant_sel, 2'd0);
    step();
    step();
    rst = 1'b0;

    // Single requester, two-beat burst
    req_valid = 4'b0100; in2 = 8'hA5; req_last = 4'b0000; out_ready = 1'b1;
    #1;
    check_eq("single_idle_valid", out_valid, 1'b0);
    check_eq("single_idle_ready", req_ready, 4'b0000);
    step();
    #1;
    check_eq("single_b1_busy", busy, 1'b1);
    check_eq("single_b1_gsel", grant_sel, 2'd2);
    check_eq("single_b1_valid", out_valid, 1'b1);
    check_eq("single_b1_ready", req_ready, 4'b0100);
    check_eq("single_b1_data", out_data, 8'hA5);
    check_eq("single_b1_last", out_last, 1'b0);
    step();
    req_last = 4'b0100;
    #1;
    check_eq("single_b2_data", out_data, 8'hA5);
    check_eq("single_b2_last", out_last, 1'b1);
    step();
    req_valid = 4'b0000; req_last = 4'b0000;
    #1;
    check_eq("single_end_busy", busy, 1'b0);
    check_eq("single_end_valid", out_valid, 1'b0);
    step();

    // Round-robin with all requesters issuing single-beat bursts
    do_reset();
    in0 = rr_data[0]; in1 = rr_data[1]; in2 = rr_data[2]; in3 = rr_data[3];
    req_valid = 4'b1111; req_last = 4'b1111;
    #1;
    check_eq("rr_start_busy", busy, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      check_eq("rr_gsel", grant_sel, 32'(k % 4));
      check_eq("rr_data", out_data, rr_data[k % 4]);
      check_eq("rr_last", out_last, 1'b1);
      step();
      #1;
      check_eq("rr_bubble", busy, 1'b0);
    end

    // Burst cap: requester 1 never signals last, requester 2 waits
    req_valid = 4'b0110; req_last = 4'b0000;
    step();
    for (int b = 0; b < 4; b++) begin
      #1;
      check_eq("cap_gsel", grant_sel, 2'd1);
      check_eq("cap_valid", out_valid, 1'b1);
      check_eq("cap_last", out_last, (b == 3) ? 1'b1 : 1'b0);
      step();
    end
    #1;
    check_eq("cap_end_busy", busy, 1'b0);
    step();
    #1;
    check_eq("cap_next_gsel", grant_sel, 2'd2);
    check_eq("cap_next_busy", busy, 1'b1);
    req_last = 4'b0100;
    step();

    // Backpressure during a requester 3 burst
    req_valid = 4'b1000; req_last = 4'b0000; in3 = 8'h3C; out_ready = 1'b1;
    step();
    #1;
    check_eq("bp_c1_gsel", grant_sel, 2'd3);
    check_eq("bp_c1_ready", req_ready, 4'b1000);
    check_eq("bp_c1_data", out_data, 8'h3C);
    step();
    out_ready = 1'b0;
    #1;
    check_eq("bp_c2_ready", req_ready, 4'b0000);
    check_eq("bp_c2_valid", out_valid, 1'b1);
    step();
    #1;
    check_eq("bp_c3_ready", req_ready, 4'b0000);
    check_eq("bp_c3_data", out_data, 8'h3C);
    step();
    out_ready = 1'b1;
    #1;
    check_eq("bp_c4_ready", req_ready, 4'b1000);
    check_eq("bp_c4_last", out_last, 1'b0);
    step();
    #1;
    check_eq("bp_c5_last", out_last, 1'b0);
    step();
    #1;
    check_eq("bp_c6_last", out_last, 1'b1);
    step();
    #1;
    check_eq("bp_end_busy", busy, 1'b0);

    // Asynchronous reset in the middle of a requester 2 burst
    req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b1;
    step();
    #1;
    check_eq("mid_gsel", grant_sel, 2'd2);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_ready", req_ready, 4'b0000);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_gsel", grant_sel, 2'd0);
    step();
    rst = 1'b0;
    req_valid = 4'b1111; req_last = 4'b1111;
    #1;
    check_eq("post_rst_idle", busy, 1'b0);
    step();
    #1;
    check_eq("post_rst_gsel", grant_sel, 2'd0);
    check_eq("post_rst_busy", busy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
